// File: rtl/ysyx_040066_csr_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// mcause codes, mstatus bit positions and controller state encoding.
package ysyx_040066_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [63:0] MSTATUS_RST = 64'h1800;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_REDIR = 1'b1;

endpackage

// File: rtl/ysyx_040066_csr_file.sv
// M-mode trap CSR storage: read mux, write masking, and trap side effects
// layered on top of a same-cycle software write.
module ysyx_040066_csr_file
    import ysyx_040066_csr_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MTIE_BIT = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            timer_intr,
    input  logic            we_i,
    input  logic [11:0]     addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            trap_enter_i,
    input  logic            trap_mret_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    output logic            mstatus_mie_o,
    output logic            mie_mtie_o,
    output logic            mip_mtip_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o
);

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic            mip_mtip_q;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mstatus_rd;

    always_comb begin
        mstatus_rd                                = XLEN'(MSTATUS_RST);
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_rd[MSTATUS_MIE]                   = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE]                  = mstatus_mpie_q;
    end

    always_comb begin
        rdata_o   = '0;
        illegal_o = 1'b0;
        case (addr_i)
            CSR_MSTATUS:  rdata_o = mstatus_rd;
            CSR_MIE:      rdata_o[MTIE_BIT] = mie_mtie_q;
            CSR_MTVEC:    rdata_o = mtvec_q;
            CSR_MSCRATCH: rdata_o = mscratch_q;
            CSR_MEPC:     rdata_o = mepc_q;
            CSR_MCAUSE:   rdata_o = mcause_q;
            CSR_MIP: begin
                rdata_o[MTIE_BIT] = mip_mtip_q;
                illegal_o         = 1'b1;
            end
            default:      illegal_o = 1'b1;
        endcase
    end

    // The software write is applied first; trap effects then overwrite it.
    // NOTE: blocking assignments here are deliberate so the trap block sees
    // the post-write values; a default for every _d avoids latches.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mscratch_d     = mscratch_q;
        if (we_i) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wdata_i[MSTATUS_MIE];
                    mstatus_mpie_d = wdata_i[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_mtie_d = wdata_i[MTIE_BIT];
                CSR_MTVEC:    mtvec_d    = {wdata_i[XLEN-1:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = wdata_i;
                CSR_MEPC:     mepc_d     = {wdata_i[XLEN-1:1], 1'b0};
                CSR_MCAUSE:   mcause_d   = wdata_i;
                default: ;
            endcase
        end
        if (trap_enter_i) begin
            mepc_d         = {trap_epc_i[XLEN-1:1], 1'b0};
            mcause_d       = trap_cause_i;
            mstatus_mpie_d = mstatus_mie_d;
            mstatus_mie_d  = 1'b0;
        end else if (trap_mret_i) begin
            mstatus_mie_d  = mstatus_mpie_d;
            mstatus_mpie_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= MSTATUS_RST[MSTATUS_MIE];
            mstatus_mpie_q <= MSTATUS_RST[MSTATUS_MPIE];
            mie_mtie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mscratch_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mip_mtip_q     <= timer_intr;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mscratch_q     <= mscratch_d;
        end
    end

    assign mstatus_mie_o = mstatus_mie_q;
    assign mie_mtie_o    = mie_mtie_q;
    assign mip_mtip_o    = mip_mtip_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: rtl/ysyx_040066_trap_ctrl.sv
// Machine-mode trap controller: picks ecall / mret / timer interrupt at
// retire, flushes the pipeline and hands the new PC to fetch.
module ysyx_040066_trap_ctrl
    import ysyx_040066_csr_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MTIE_BIT = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            timer_intr,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [XLEN-1:0] wb_next_pc,
    input  logic            wb_ecall,
    input  logic            wb_mret,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_err,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            run, retire;
    logic            ev_ecall, ev_mret, ev_irq, trap_evt;
    logic            mstatus_mie, mie_mtie, mip_mtip, csr_illegal;
    logic [XLEN-1:0] mtvec, mepc, target_pc, trap_cause;

    assign run      = (state_q == ST_RUN);
    assign retire   = run & wb_valid;
    assign ev_ecall = retire & wb_ecall;
    assign ev_mret  = retire & wb_mret & ~wb_ecall;
    assign ev_irq   = retire & ~wb_ecall & ~wb_mret & mstatus_mie & mie_mtie & mip_mtip;
    assign trap_evt = ev_ecall | ev_mret | ev_irq;

    assign target_pc  = ev_mret ? mepc : mtvec;
    assign trap_cause = ev_ecall ? XLEN'(CAUSE_ECALL_M) : XLEN'(CAUSE_MTI);
    assign csr_err    = csr_we & wb_valid & csr_illegal;

    ysyx_040066_csr_file #(
        .XLEN    (XLEN),
        .MTIE_BIT(MTIE_BIT)
    ) u_csr_file (
        .clk          (clk),
        .rst          (rst),
        .timer_intr   (timer_intr),
        .we_i         (csr_we & retire),
        .addr_i       (csr_addr),
        .wdata_i      (csr_wdata),
        .trap_enter_i (ev_ecall | ev_irq),
        .trap_mret_i  (ev_mret),
        .trap_epc_i   (ev_ecall ? wb_pc : wb_next_pc),
        .trap_cause_i (trap_cause),
        .rdata_o      (csr_rdata),
        .illegal_o    (csr_illegal),
        .mstatus_mie_o(mstatus_mie),
        .mie_mtie_o   (mie_mtie),
        .mip_mtip_o   (mip_mtip),
        .mtvec_o      (mtvec),
        .mepc_o       (mepc)
    );

    // A redirect accepted in its own trap cycle completes the handshake there.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_RUN: begin
                if (trap_evt) begin
                    redirect_pc_d = target_pc;
                    state_d       = redirect_ready ? ST_RUN : ST_REDIR;
                end
            end
            ST_REDIR: if (redirect_ready) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign flush          = trap_evt | (state_q == ST_REDIR);
    assign redirect_valid = flush;
    assign redirect_pc    = trap_evt ? target_pc : redirect_pc_q;

endmodule

// File: tb/tb_ysyx_040066_trap_ctrl.sv
// Self-checking bench for the trap controller; redirect targets go through
// a scoreboard queue and are matched on each accepted handshake.
module tb_ysyx_040066_trap_ctrl;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [63:0] IRQ_CAUSE  = 64'h8000_0000_0000_0007;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_intr;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [63:0] wb_next_pc;
    logic        wb_ecall;
    logic        wb_mret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_err;
    logic        flush;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ready;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    ysyx_040066_trap_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .timer_intr    (timer_intr),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_next_pc    (wb_next_pc),
        .wb_ecall      (wb_ecall),
        .wb_mret       (wb_mret),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_err       (csr_err),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic read_csr(input string tag, input logic [11:0] a, input logic [63:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic idle_wb();
        wb_valid = 1'b0;
        wb_ecall = 1'b0;
        wb_mret  = 1'b0;
        csr_we   = 1'b0;
    endtask

    // Called just after a rising edge; retires one instruction over one cycle.
    task automatic retire(input logic [63:0] pc, input logic [63:0] npc, input logic ecall,
                          input logic mret, input logic we, input logic [11:0] a,
                          input logic [63:0] d, input logic exp_trap);
        wb_valid   = 1'b1;
        wb_pc      = pc;
        wb_next_pc = npc;
        wb_ecall   = ecall;
        wb_mret    = mret;
        csr_we     = we;
        csr_addr   = a;
        csr_wdata  = d;
        @(negedge clk);
        check("retire_flush", {63'b0, flush}, {63'b0, exp_trap});
        check("retire_rvalid", {63'b0, redirect_valid}, {63'b0, exp_trap});
        @(posedge clk);
        #1;
        idle_wb();
    endtask

    task automatic write_csr(input logic [11:0] a, input logic [63:0] d);
        retire(64'h0, 64'h4, 1'b0, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic accept();
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_ready = 1'b0;
    endtask

    // Scoreboard: every accepted redirect must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && redirect_valid && redirect_ready) begin
                if (exp_q.size() == 0)
                    check("redir_unexpected", {63'b0, redirect_valid}, 64'd0);
                else
                    check("redir_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int held;
        rst            = 1'b0;
        timer_intr     = 1'b0;
        redirect_ready = 1'b0;
        wb_pc          = '0;
        wb_next_pc     = '0;
        csr_addr       = '0;
        csr_wdata      = '0;
        idle_wb();
        #1;
        check("rst_flush", {63'b0, flush}, 64'd0);
        check("rst_rvalid", {63'b0, redirect_valid}, 64'd0);
        check("rst_rpc", redirect_pc, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        read_csr("rst_mstatus", A_MSTATUS, 64'h1800);
        read_csr("rst_mie", A_MIE, 64'h0);
        read_csr("rst_mtvec", A_MTVEC, 64'h0);
        read_csr("rst_mscratch", A_MSCRATCH, 64'h0);
        read_csr("rst_mepc", A_MEPC, 64'h0);
        read_csr("rst_mcause", A_MCAUSE, 64'h0);
        read_csr("rst_mip", A_MIP, 64'h0);

        // Setup writes and masking
        @(posedge clk);
        #1;
        write_csr(A_MTVEC, 64'h8000_0103);
        write_csr(A_MIE, 64'h80);
        write_csr(A_MSTATUS, 64'h8);
        write_csr(A_MSCRATCH, 64'hdead_beef_0123_4567);
        read_csr("mtvec_mask", A_MTVEC, 64'h8000_0100);
        read_csr("mie_wr", A_MIE, 64'h80);
        read_csr("mstatus_wr", A_MSTATUS, 64'h1808);
        read_csr("mscratch_wr", A_MSCRATCH, 64'hdead_beef_0123_4567);

        // Timer interrupt taken on a plain retire
        timer_intr = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        read_csr("mip_pending", A_MIP, 64'h80);
        @(posedge clk);
        #1;
        exp_q.push_back(64'h8000_0100);
        retire(64'h8000_0040, 64'h8000_0044, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1);
        accept();
        read_csr("irq_mepc", A_MEPC, 64'h8000_0044);
        read_csr("irq_mcause", A_MCAUSE, IRQ_CAUSE);
        read_csr("irq_mstatus", A_MSTATUS, 64'h1880);

        // mret held for 3 not-ready cycles
        @(posedge clk);
        #1;
        exp_q.push_back(64'h8000_0044);
        held = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wb_valid = 1'b1;
                wb_mret  = 1'b1;
                wb_pc    = 64'h8000_0100;
            end
            redirect_ready = (i == 3);
            @(negedge clk);
            if (flush && redirect_valid) held++;
            check("mret_hold_pc", redirect_pc, 64'h8000_0044);
            @(posedge clk);
            #1;
            idle_wb();
        end
        redirect_ready = 1'b0;
        @(negedge clk);
        check("mret_hold_cycles", 64'(held), 64'd4);
        check("mret_done_rvalid", {63'b0, redirect_valid}, 64'd0);
        check("mret_done_flush", {63'b0, flush}, 64'd0);
        read_csr("mret_mstatus", A_MSTATUS, 64'h1888);
        @(posedge clk);
        #1;

        // ecall wins over the pending interrupt
        exp_q.push_back(64'h8000_0100);
        retire(64'h8000_0010, 64'h8000_0014, 1'b1, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1);
        accept();
        read_csr("ecall_mcause", A_MCAUSE, 64'd11);
        read_csr("ecall_mepc", A_MEPC, 64'h8000_0010);
        read_csr("ecall_mstatus", A_MSTATUS, 64'h1880);
        read_csr("ecall_mip", A_MIP, 64'h80);
        @(posedge clk);
        #1;
        retire(64'h8000_0100, 64'h8000_0104, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0);

        // mret with a same-cycle mepc write: redirect uses the old mepc
        exp_q.push_back(64'h8000_0010);
        retire(64'h8000_0104, 64'h8000_0108, 1'b0, 1'b1, 1'b1, A_MEPC, 64'h8000_0015, 1'b1);
        accept();
        read_csr("mret_wr_mepc", A_MEPC, 64'h8000_0014);
        read_csr("mret_wr_mstatus", A_MSTATUS, 64'h1888);
        @(posedge clk);
        #1;

        // Interrupt left pending is taken once MIE is restored
        exp_q.push_back(64'h8000_0100);
        retire(64'h8000_0014, 64'h8000_0018, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1);
        accept();
        read_csr("irq2_mepc", A_MEPC, 64'h8000_0018);
        read_csr("irq2_mcause", A_MCAUSE, IRQ_CAUSE);

        // Read-only and unimplemented addresses
        @(posedge clk);
        #1;
        wb_valid  = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = A_MIP;
        csr_wdata = 64'hFFFF;
        #1;
        check("mip_wr_err", {63'b0, csr_err}, 64'd1);
        csr_addr = 12'h7C0;
        #1;
        check("unimpl_wr_err", {63'b0, csr_err}, 64'd1);
        check("unimpl_rdata", csr_rdata, 64'h0);
        csr_addr = A_MSCRATCH;
        #1;
        check("legal_wr_err", {63'b0, csr_err}, 64'd0);
        csr_addr = A_MIP;
        @(posedge clk);
        #1;
        idle_wb();
        read_csr("mip_unchanged", A_MIP, 64'h80);
        check("mip_err_idle", {63'b0, csr_err}, 64'd0);

        // Reset asserted mid-redirect aborts it
        timer_intr = 1'b0;
        @(posedge clk);
        #1;
        retire(64'h8000_0020, 64'h8000_0024, 1'b1, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1);
        check("redir_pending", {63'b0, redirect_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_rvalid", {63'b0, redirect_valid}, 64'd0);
        check("abort_flush", {63'b0, flush}, 64'd0);
        read_csr("abort_mstatus", A_MSTATUS, 64'h1800);
        read_csr("abort_mtvec", A_MTVEC, 64'h0);
        read_csr("abort_mepc", A_MEPC, 64'h0);
        read_csr("abort_mcause", A_MCAUSE, 64'h0);
        read_csr("abort_mip", A_MIP, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", {63'b0, redirect_valid}, 64'd0);
        @(posedge clk);
        #1;
        retire(64'h0, 64'h4, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
